// File: rtl/reg_dump_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reg_dump_pkg
//  Purpose  : Shared types and constants for the register-file dump streamer.
//             FSM state encoding, bytes per captured word, header marker byte.
//  Macros   : REG_DUMP_PC_EN (consumed by reg_dump_ctrl; HDR state reserved)
//  Revision : 1.0 - initial release
// ============================================================================
package reg_dump_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        SEL  = 3'd2,
        CAP  = 3'd3,
        SEND = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam int         BYTES_PER_WORD = 4;
    localparam logic [7:0] HDR_MARKER     = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/reg_dump_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : reg_dump_ctrl_if
//  Purpose  : Bundles the register-file read port and the outgoing byte
//             stream of the dump controller.
//  Ports    : reg_sel   - register index into the register file
//             reg_data  - combinational read data for reg_sel
//             out_data  - stream byte
//             out_valid - out_data valid
//             out_ready - sink accepts byte when out_valid & out_ready
//  Modports : master (dump controller), slave (register file + byte sink)
//  Revision : 1.0 - initial release
// ============================================================================
interface reg_dump_ctrl_if #(
    parameter int SEL_W = 5
);
    logic [SEL_W-1:0] reg_sel;
    logic [31:0]      reg_data;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output reg_sel,
        output out_data,
        output out_valid,
        input  reg_data,
        input  out_ready
    );

    modport slave (
        input  reg_sel,
        input  out_data,
        input  out_valid,
        output reg_data,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/reg_dump_ctrl_word2byte_ser.sv
`default_nettype none
// ============================================================================
//  Module   : word2byte_ser
//  Purpose  : Loads a 32-bit word and presents it as BYTES_PER_WORD bytes,
//             MSB first. The byte only advances on an accepted transfer, so
//             the presented byte is stable while the sink stalls.
//  Ports    : clk, rstn - clock, asynchronous active-low reset
//             load_i    - capture word_i, restart byte counter
//             word_i    - word to serialise
//             en_i      - owner is presenting the byte as valid
//             ready_i   - sink ready
//             byte_o    - current byte (word MSB first)
//             last_o    - the final byte of the word is being accepted
//  Revision : 1.0 - initial release
// ============================================================================
module word2byte_ser
    import reg_dump_pkg::*;
(
    input  wire        clk,
    input  wire        rstn,
    input  wire        load_i,
    input  wire [31:0] word_i,
    input  wire        en_i,
    input  wire        ready_i,
    output logic [7:0] byte_o,
    output logic       last_o
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [31:0] shift_q, shift_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic        accept;

    always_comb begin
        accept  = en_i & ready_i;
        shift_d = shift_q;
        bcnt_d  = bcnt_q;
        if (load_i) begin
            shift_d = word_i;
            bcnt_d  = 2'd0;
        end else if (accept) begin
            shift_d = {shift_q[23:0], 8'h00};
            bcnt_d  = bcnt_q + 2'd1;
        end
        byte_o = shift_q[31:24];
        last_o = accept && (bcnt_q == LAST_BYTE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift_q <= '0;
            bcnt_q  <= '0;
        end else begin
            shift_q <= shift_d;
            bcnt_q  <= bcnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_dump_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : reg_dump_ctrl
//  Purpose  : On a start pulse, walks reg_sel over registers 0..NUM_REGS-1,
//             captures each word once and streams it out as bytes, MSB
//             first, on a valid/ready byte stream.
//  Ports    : clk, rstn - clock, asynchronous active-low reset
//             start     - dump request (ignored while busy)
//             abort     - synchronous cancel, back to IDLE, no done pulse
//             pc        - PC value for the optional header
//             bus       - register read port + byte stream (master side)
//             busy      - dump in progress (any state except IDLE)
//             done      - one-cycle pulse after the last byte is accepted
//  Macros   : REG_DUMP_PC_EN - when defined, a header of 0xA5 followed by
//             the PC (captured on the start cycle, MSB first) precedes the
//             register bytes. Undefined: pc is unused.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_dump_ctrl
    import reg_dump_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int SEL_W    = 5
)(
    input  wire             clk,
    input  wire             rstn,
    input  wire             start,
    input  wire             abort,
    input  wire [31:0]      pc,
    reg_dump_ctrl_if.master bus,
    output logic            busy,
    output logic            done
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REGS - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [SEL_W-1:0] reg_sel_q, reg_sel_d;

    logic             ser_load;
    logic [31:0]      ser_word;
    logic             ser_en;
    logic [7:0]       ser_byte;
    logic             ser_last;
    logic             out_valid;
    logic             mark_phase;

`ifdef REG_DUMP_PC_EN
    logic [31:0]      pc_q, pc_d;
    logic             mark_q, mark_d;   // header marker byte already accepted
`else
    logic             unused_pc;
    assign unused_pc = ^pc;
`endif

    word2byte_ser u_ser (
        .clk     (clk),
        .rstn    (rstn),
        .load_i  (ser_load),
        .word_i  (ser_word),
        .en_i    (ser_en),
        .ready_i (bus.out_ready),
        .byte_o  (ser_byte),
        .last_o  (ser_last)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        reg_sel_d  = reg_sel_q;
        ser_load   = 1'b0;
        ser_word   = bus.reg_data;
        ser_en     = 1'b0;
        out_valid  = 1'b0;
        mark_phase = 1'b0;
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
`ifdef REG_DUMP_PC_EN
        pc_d       = pc_q;
        mark_d     = mark_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = '0;
`ifdef REG_DUMP_PC_EN
                    pc_d    = pc;
                    mark_d  = 1'b0;
                    state_d = HDR;
`else
                    state_d = SEL;
`endif
                end
            end
`ifdef REG_DUMP_PC_EN
            HDR: begin
                out_valid = 1'b1;
                if (!mark_q) begin
                    // Marker byte comes from a constant; the PC word is
                    // loaded into the serialiser as the marker is taken.
                    mark_phase = 1'b1;
                    if (bus.out_ready) begin
                        mark_d   = 1'b1;
                        ser_load = 1'b1;
                        ser_word = pc_q;
                    end
                end else begin
                    ser_en = 1'b1;
                    if (ser_last) begin
                        state_d = SEL;
                    end
                end
            end
`endif
            SEL: begin
                // reg_sel is registered; CAP sees settled reg_data.
                reg_sel_d = idx_q;
                state_d   = CAP;
            end
            CAP: begin
                ser_load = 1'b1;
                state_d  = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                ser_en    = 1'b1;
                if (ser_last) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = SEL;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Abort overrides everything, including a start in IDLE.
        if (abort) begin
            state_d = IDLE;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            reg_sel_q <= '0;
`ifdef REG_DUMP_PC_EN
            pc_q      <= '0;
            mark_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            reg_sel_q <= reg_sel_d;
`ifdef REG_DUMP_PC_EN
            pc_q      <= pc_d;
            mark_q    <= mark_d;
`endif
        end
    end

    assign bus.reg_sel   = reg_sel_q;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = mark_phase ? HDR_MARKER : ser_byte;

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_dump_ctrl
//  Purpose  : Self-checking bench for reg_dump_ctrl. A register-file array
//             feeds reg_data; every accepted byte is collected and compared
//             with a stream built directly from the register contents.
//  Macros   : REG_DUMP_PC_EN - expects the 5-byte header when defined
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_dump_ctrl;

    localparam int NUM_REGS = 32;
    localparam int SEL_W    = 5;
`ifdef REG_DUMP_PC_EN
    localparam int HDR_BYTES = 5;
`else
    localparam int HDR_BYTES = 0;
`endif
    localparam int STREAM_LEN = HDR_BYTES + 4 * NUM_REGS;

    logic        clk   = 1'b0;
    logic        rstn  = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] pc    = 32'h0000_0048;
    logic        ready = 1'b0;
    logic        busy;
    logic        done;

    logic [31:0] rf [NUM_REGS];
    logic [7:0]  got [$];
    logic [7:0]  exp_q [$];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int stall_viol = 0;
    logic       prev_stall = 1'b0;
    logic       prev_abort = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    reg_dump_ctrl_if #(.SEL_W(SEL_W)) bus ();

    assign bus.reg_data  = rf[bus.reg_sel];
    assign bus.out_ready = ready;

    reg_dump_ctrl #(
        .NUM_REGS (NUM_REGS),
        .SEL_W    (SEL_W)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .start (start),
        .abort (abort),
        .pc    (pc),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Sink / monitor: inputs change just after posedge, so the negedge sees
    // exactly what the next posedge will act on.
    always @(negedge clk) begin
        if (rstn) begin
            if (prev_stall && !prev_abort &&
                !(bus.out_valid === 1'b1 && bus.out_data === prev_data))
                stall_viol <= stall_viol + 1;
            if (bus.out_valid === 1'b1 && ready)
                got.push_back(bus.out_data);
            if (done === 1'b1)
                done_cnt <= done_cnt + 1;
            prev_stall <= (bus.out_valid === 1'b1) && !ready;
            prev_data  <= bus.out_data;
            prev_abort <= abort;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    // Expected stream: optional header, then each register MSB first.
    task automatic build_exp(input logic [31:0] pcv);
        exp_q.delete();
`ifdef REG_DUMP_PC_EN
        exp_q.push_back(8'hA5);
        for (int b = 3; b >= 0; b--) exp_q.push_back(8'(pcv >> (8 * b)));
`endif
        for (int k = 0; k < NUM_REGS; k++)
            for (int b = 3; b >= 0; b--) exp_q.push_back(8'(rf[k] >> (8 * b)));
    endtask

    function automatic int first_bad();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= got.size()) return i;
            if (got[i] !== exp_q[i]) return i;
        end
        return -1;
    endfunction

    // mode: 0 ready=1, 1 toggling, 2 random. act_kind: 0 none, 1 extra
    // start, 2 abort, 3 reset, fired once act_at bytes have been accepted.
    task automatic do_dump(input int mode, input int act_kind, input int act_at,
                           input bit mutate, output int lat, output bit tmo,
                           output logic v_after, output logic b_after,
                           output int sz_after, output int d_done, output int d_viol);
        int  done0;
        int  viol0;
        bit  acted;
        got.delete();
        build_exp(pc);
        done0 = done_cnt; viol0 = stall_viol;
        lat = -1; tmo = 1'b1; acted = 1'b0;
        v_after = 1'bx; b_after = 1'bx; sz_after = -1;
        @(posedge clk); #1;
        start = 1'b1; ready = 1'b1;
        for (int c = 1; c <= 2000; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            case (mode)
                0:       ready = 1'b1;
                1:       ready = (c % 2 == 1);
                default: ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk); #1;
            if (lat < 0 && bus.out_valid === 1'b1) lat = c;
            // Once a register's first byte is out, its word is already
            // captured; changing the RF now must not alter the stream.
            if (mutate && got.size() > HDR_BYTES)
                rf[(got.size() - 1 - HDR_BYTES) / 4] = $urandom();
            if (done_cnt != done0) begin
                repeat (8) begin @(posedge clk); #1 ready = 1'b1; end
                tmo = 1'b0;
                break;
            end
            if (!acted && act_kind != 0 && got.size() >= act_at) begin
                acted = 1'b1;
                if (act_kind == 1) begin
                    @(posedge clk); #1 start = 1'b1;
                end else if (act_kind == 2) begin
                    @(posedge clk); #1 abort = 1'b1;
                    @(posedge clk); #1 abort = 1'b0;
                    v_after = bus.out_valid; b_after = busy; sz_after = got.size();
                    repeat (20) @(posedge clk);
                    tmo = 1'b0;
                    break;
                end else begin
                    #2 rstn = 1'b0;
                    #1 v_after = bus.out_valid; b_after = busy; sz_after = got.size();
                    repeat (2) @(posedge clk);
                    #1 rstn = 1'b1;
                    repeat (3) @(posedge clk);
                    tmo = 1'b0;
                    break;
                end
            end
        end
        @(negedge clk); #1;
        d_done = done_cnt - done0;
        d_viol = stall_viol - viol0;
        ready = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (bus.reg_sel !== 5'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", bus.reg_sel); end
        checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", bus.out_data); end
        @(posedge clk); #1 rstn = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_basic();
        int lat, sz, dd, dv, fb; bit tmo; logic va, ba;
        logic [7:0] b47 [4];
        b47[0] = 8'h10; b47[1] = 8'h00; b47[2] = 8'h00; b47[3] = 8'h01;
        for (int k = 0; k < NUM_REGS; k++) rf[k] = 32'h1000_0000 + k;
        do_dump(0, 0, 0, 1'b0, lat, tmo, va, ba, sz, dd, dv);
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL basic_timeout got %b want 0", tmo); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL basic_latency got %0d want 3", lat); end
        checks++; if (got.size() !== STREAM_LEN) begin errors++; $display("FAIL basic_count got %0d want %0d", got.size(), STREAM_LEN); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got.size() <= HDR_BYTES + 4 + i || got[HDR_BYTES + 4 + i] !== b47[i]) begin
                errors++; $display("FAIL basic_reg1_byte%0d got %h want %h", i,
                                   (got.size() > HDR_BYTES + 4 + i) ? got[HDR_BYTES + 4 + i] : 8'hxx, b47[i]);
            end
        end
        fb = first_bad();
        checks++; if (fb !== -1) begin errors++; $display("FAIL basic_stream first bad index %0d want none", fb); end
        checks++; if (dd !== 1) begin errors++; $display("FAIL basic_done_pulses got %0d want 1", dd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b want 0", busy); end
`ifdef REG_DUMP_PC_EN
        begin
            logic [7:0] hdr [5];
            hdr[0] = 8'hA5; hdr[1] = 8'h00; hdr[2] = 8'h00; hdr[3] = 8'h00; hdr[4] = 8'h48;
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got.size() <= i || got[i] !== hdr[i]) begin
                    errors++; $display("FAIL hdr_byte%0d got %h want %h", i, (got.size() > i) ? got[i] : 8'hxx, hdr[i]);
                end
            end
        end
`endif
    endtask

    task automatic test_stall();
        int lat, sz, dd, dv, fb; bit tmo; logic va, ba;
        for (int k = 0; k < NUM_REGS; k++) rf[k] = 32'h1000_0000 + k;
        do_dump(1, 0, 0, 1'b0, lat, tmo, va, ba, sz, dd, dv);
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL stall_timeout got %b want 0", tmo); end
        checks++; if (got.size() !== STREAM_LEN) begin errors++; $display("FAIL stall_count got %0d want %0d", got.size(), STREAM_LEN); end
        fb = first_bad();
        checks++; if (fb !== -1) begin errors++; $display("FAIL stall_stream first bad index %0d want none", fb); end
        checks++; if (dv !== 0) begin errors++; $display("FAIL stall_stability violations %0d want 0", dv); end
        checks++; if (dd !== 1) begin errors++; $display("FAIL stall_done_pulses got %0d want 1", dd); end
    endtask

    task automatic test_random();
        int lat, sz, dd, dv, fb; bit tmo; logic va, ba;
        for (int k = 0; k < NUM_REGS; k++) rf[k] = $urandom();
        do_dump(2, 0, 0, 1'b1, lat, tmo, va, ba, sz, dd, dv);
        checks++; if (got.size() !== STREAM_LEN) begin errors++; $display("FAIL rand_count got %0d want %0d", got.size(), STREAM_LEN); end
        fb = first_bad();
        checks++; if (fb !== -1) begin errors++; $display("FAIL rand_stream first bad index %0d want none", fb); end
        checks++; if (dv !== 0) begin errors++; $display("FAIL rand_stability violations %0d want 0", dv); end
        checks++; if (dd !== 1) begin errors++; $display("FAIL rand_done_pulses got %0d want 1", dd); end
    endtask

    task automatic test_start_busy();
        int lat, sz, dd, dv, fb; bit tmo; logic va, ba;
        for (int k = 0; k < NUM_REGS; k++) rf[k] = $urandom();
        do_dump(0, 1, 40, 1'b0, lat, tmo, va, ba, sz, dd, dv);
        checks++; if (got.size() !== STREAM_LEN) begin errors++; $display("FAIL restart_count got %0d want %0d", got.size(), STREAM_LEN); end
        fb = first_bad();
        checks++; if (fb !== -1) begin errors++; $display("FAIL restart_stream first bad index %0d want none", fb); end
        checks++; if (dd !== 1) begin errors++; $display("FAIL restart_done_pulses got %0d want 1", dd); end
    endtask

    task automatic test_abort();
        int lat, sz, dd, dv, fb; bit tmo; logic va, ba;
        for (int k = 0; k < NUM_REGS; k++) rf[k] = $urandom();
        do_dump(0, 2, 50, 1'b0, lat, tmo, va, ba, sz, dd, dv);
        checks++; if (va !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", va); end
        checks++; if (ba !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", ba); end
        checks++; if (dd !== 0) begin errors++; $display("FAIL abort_done_pulses got %0d want 0", dd); end
        checks++; if (got.size() !== sz) begin errors++; $display("FAIL abort_quiet bytes %0d want %0d", got.size(), sz); end
        do_dump(0, 0, 0, 1'b0, lat, tmo, va, ba, sz, dd, dv);
        fb = first_bad();
        checks++; if (fb !== -1 || got.size() !== STREAM_LEN) begin
            errors++; $display("FAIL abort_restart first bad %0d count %0d want none/%0d", fb, got.size(), STREAM_LEN);
        end
    endtask

    task automatic test_reset_mid();
        int lat, sz, dd, dv, fb; bit tmo; logic va, ba;
        for (int k = 0; k < NUM_REGS; k++) rf[k] = $urandom();
        do_dump(0, 3, 70, 1'b0, lat, tmo, va, ba, sz, dd, dv);
        checks++; if (va !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %b want 0", va); end
        checks++; if (ba !== 1'b0) begin errors++; $display("FAIL rst_async_busy got %b want 0", ba); end
        checks++; if (dd !== 0) begin errors++; $display("FAIL rst_done_pulses got %0d want 0", dd); end
        do_dump(0, 0, 0, 1'b0, lat, tmo, va, ba, sz, dd, dv);
        fb = first_bad();
        checks++; if (fb !== -1 || got.size() !== STREAM_LEN) begin
            errors++; $display("FAIL rst_restart first bad %0d count %0d want none/%0d", fb, got.size(), STREAM_LEN);
        end
        checks++; if (dd !== 1) begin errors++; $display("FAIL rst_restart_done got %0d want 1", dd); end
    endtask

    task automatic test_start_abort_idle();
        int done0;
        got.delete();
        done0 = done_cnt;
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_abort_busy got %b want 0", busy); end
        repeat (8) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (got.size() !== 0 || done_cnt !== done0) begin
            errors++; $display("FAIL start_abort_quiet bytes %0d dones %0d want 0/0", got.size(), done_cnt - done0);
        end
    endtask

    initial begin
        for (int k = 0; k < NUM_REGS; k++) rf[k] = 32'h0;
        test_reset();
        test_basic();
        test_stall();
        test_random();
        test_start_busy();
        test_abort();
        test_reset_mid();
        test_start_abort_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
